fft_output_serializer: RTL and testbench

- Parametrised parallel-to-serial unloader for the FFT output stage.
- Accepts one block of LANES complex words in a single beat and emits them one word per cycle, lane 0 first.
- Applies the per-block IFFT post-processing: swap real and imaginary halves, then scale by 2^-SCALE_SHIFT.
- Replaces external hold/select control with valid/ready handshakes on both sides. A one-block skid buffer gives gap-free streaming between blocks.

---
 rtl/fft_out_pkg.sv | 46 ++++
 rtl/fft_out_word_xform.sv | 20 ++
 rtl/fft_output_serializer.sv | 121 ++++++++++++
 tb/tb_fft_output_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_out_pkg.sv
// Shared definitions for the FFT output serializer.
// Provides the half-width derivation, the complex-word IFFT transform
// (swap real/imag, arithmetic shift both halves) and parameter-legality checks.
package fft_out_pkg;

  // Widest complex word the transform function handles.
  localparam int unsigned MAX_W = 64;
  localparam int unsigned MAX_H = MAX_W / 2;

  typedef enum logic {
    MODE_FFT  = 1'b0,
    MODE_IFFT = 1'b1
  } mode_e;

  function automatic int unsigned half_w(input int unsigned dw);
    return dw / 2;
  endfunction

  function automatic bit params_ok(input int unsigned dw,
                                   input int unsigned lanes,
                                   input int unsigned sh);
    return (dw % 2 == 0) && (dw >= 2) && (dw <= MAX_W) &&
           (lanes >= 2) && (sh < dw / 2);
  endfunction

  // Swap halves of an h-bit-per-half complex word, then arithmetic-shift each
  // half right by sh. Each half is first moved to the top of a MAX_H signed
  // container so a single >>> both sign-extends and scales.
  function automatic logic [MAX_W-1:0] cplx_xform(input logic [MAX_W-1:0] w,
                                                  input int unsigned     h,
                                                  input int unsigned     sh);
    logic [MAX_W-1:0]        mask;
    logic signed [MAX_H-1:0] re_top;
    logic signed [MAX_H-1:0] im_top;
    logic signed [MAX_H-1:0] re_s;
    logic signed [MAX_H-1:0] im_s;
    mask   = (MAX_W'(1) << h) - MAX_W'(1);
    re_top = MAX_H'(w >> h) << (MAX_H - h);
    im_top = MAX_H'(w) << (MAX_H - h);
    re_s   = re_top >>> (MAX_H - h + sh);
    im_s   = im_top >>> (MAX_H - h + sh);
    // New real half is the scaled imaginary part and vice versa.
    return ((MAX_W'(im_s) & mask) << h) | (MAX_W'(re_s) & mask);
  endfunction

endpackage

// File: rtl/fft_out_word_xform.sv
// Combinational per-word post-processing: pass-through (FFT) or swap+scale (IFFT).
// Latency: 0 cycles. No flow control; purely combinational.
// Ports: ifft_i selects the transform, dat_i raw word in, dat_o processed word out.
module fft_out_word_xform
  import fft_out_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SCALE_SHIFT = 6
) (
  input  logic                  ifft_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o
);

  localparam int unsigned H = half_w(DATA_WIDTH);

  assign dat_o = ifft_i ? DATA_WIDTH'(cplx_xform(MAX_W'(dat_i), H, SCALE_SHIFT))
                        : dat_i;

endmodule

// File: rtl/fft_output_serializer.sv
// Unloads one LANES-word block per handshake and streams it out one word per cycle, lane 0 first.
// Latency: lane 0 appears on out_data the cycle after accept; blocks stream back-to-back with no bubble.
// Backpressure: out_ready low freezes the shifter; a one-block skid buffer absorbs the next block, in_ready = !buf_full.
// Ports: clk/rst (async active-high); mode + in_valid/in_ready/in_data block input;
//        out_valid/out_ready/out_data/out_last serial output; busy = shifter or buffer occupied.
module fft_output_serializer
  import fft_out_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LANES       = 8,
  parameter int unsigned SCALE_SHIFT = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic                        busy
);

  localparam int unsigned BLK_W = LANES * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (!params_ok(DATA_WIDTH, LANES, SCALE_SHIFT)) begin : g_bad_params
    $error("fft_output_serializer: illegal DATA_WIDTH/LANES/SCALE_SHIFT");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] shift_q, shift_d;
  logic [BLK_W-1:0] buf_q, buf_d;
  mode_e            buf_mode_q, buf_mode_d;
  logic             buf_full_q, buf_full_d;

  logic [BLK_W-1:0] load_raw;
  logic [BLK_W-1:0] load_xf;
  logic             load_ifft;
  logic             accept;
  logic             pop;
  logic             free;

  // A held block always has priority for the next shifter load.
  assign load_raw  = buf_full_q ? buf_q : in_data;
  assign load_ifft = buf_full_q ? (buf_mode_q == MODE_IFFT) : mode;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fft_out_word_xform #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SCALE_SHIFT (SCALE_SHIFT)
    ) u_xform (
      .ifft_i (load_ifft),
      .dat_i  (load_raw[k*DATA_WIDTH +: DATA_WIDTH]),
      .dat_o  (load_xf[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign in_ready  = !buf_full_q && !rst;
  assign out_valid = (cnt_q != '0);
  assign out_last  = (cnt_q == CNT_ONE);
  assign out_data  = shift_q[DATA_WIDTH-1:0];
  assign busy      = (cnt_q != '0) || buf_full_q;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  // Shifter can take a new block this cycle: empty, or its last word leaves now.
  assign free   = (cnt_q == '0) || (pop && (cnt_q == CNT_ONE));

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_mode_d = buf_mode_q;
    buf_full_d = buf_full_q;
    if (free) begin
      if (buf_full_q) begin
        // in_ready is low here, so no accept can collide with the drain.
        shift_d    = load_xf;
        cnt_d      = CNT_FULL;
        buf_full_d = 1'b0;
      end else if (accept) begin
        shift_d = load_xf;
        cnt_d   = CNT_FULL;
      end else begin
        cnt_d = '0;
      end
    end else begin
      if (pop) begin
        shift_d = {{DATA_WIDTH{1'b0}}, shift_q[BLK_W-1:DATA_WIDTH]};
        cnt_d   = cnt_q - CNT_ONE;
      end
      if (accept) begin
        buf_d      = in_data;
        buf_mode_d = mode_e'(mode);
        buf_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_mode_q <= MODE_FFT;
      buf_full_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_mode_q <= buf_mode_d;
      buf_full_q <= buf_full_d;
    end
  end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Directed bench for fft_output_serializer with default parameters.
// Drives inputs 1ns after the rising edge, captures popped words on the falling edge.
// Summary line reports the number of checks and errors.
module tb_fft_output_serializer;

  localparam int DW = 32;
  localparam int LN = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LN*DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [DW-1:0] mon_dat[$];
  logic          mon_last[$];
  int            mon_cyc[$];

  fft_output_serializer #(
    .DATA_WIDTH  (DW),
    .LANES       (LN),
    .SCALE_SHIFT (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_dat.push_back(out_data);
      mon_last.push_back(out_last);
      mon_cyc.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_dat.delete();
    mon_last.delete();
    mon_cyc.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1ns after a rising edge; returns 1ns after the accepting edge.
  task automatic send_block(input logic [LN*DW-1:0] d, input logic m, output int acc);
    int waited;
    waited   = 0;
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      acc      = -1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [LN*DW-1:0] blk2;
    logic [LN*DW-1:0] blk3;
    logic [LN*DW-1:0] blk;
    logic [DW-1:0]    exp3[LN];
    logic [DW-1:0]    held;
    logic             held_l;
    logic [DW-1:0]    e;
    int acc, acc_b, acc_c;

    for (int k = 0; k < LN; k++) blk2[k*DW +: DW] = DW'(32'h0001_0000 * (k + 1) + k);
    blk3 = '0;
    blk3[0*DW +: DW] = 32'h0400_FC00;
    blk3[1*DW +: DW] = 32'h0000_0001;
    blk3[2*DW +: DW] = 32'h8000_7FFF;
    blk3[3*DW +: DW] = 32'hFFFF_FFFF;
    blk3[4*DW +: DW] = 32'h0040_FFC0;
    exp3[0] = 32'hFFF0_0010;
    exp3[1] = 32'h0000_0000;
    exp3[2] = 32'h01FF_FE00;
    exp3[3] = 32'hFFFF_FFFF;
    exp3[4] = 32'hFFFF_0001;
    exp3[5] = 32'h0000_0000;
    exp3[6] = 32'h0000_0000;
    exp3[7] = 32'h0000_0000;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // FFT single block
    clear_mon();
    out_ready = 1'b1;
    send_block(blk2, 1'b0, acc);
    wait_cycles(10);
    check("fft_count", mon_dat.size(), 8);
    for (int k = 0; k < LN && k < mon_dat.size(); k++) begin
      check($sformatf("fft_data%0d", k), mon_dat[k], DW'(32'h0001_0000 * (k + 1) + k));
      check($sformatf("fft_cyc%0d", k), mon_cyc[k], acc + k);
      check($sformatf("fft_last%0d", k), mon_last[k], (k == LN - 1) ? 1 : 0);
    end
    check("fft_idle_valid", out_valid, 0);
    check("fft_idle_busy", busy, 0);

    // IFFT transform
    clear_mon();
    send_block(blk3, 1'b1, acc);
    mode = 1'b0;
    wait_cycles(10);
    check("ifft_count", mon_dat.size(), 8);
    for (int k = 0; k < LN && k < mon_dat.size(); k++)
      check($sformatf("ifft_data%0d", k), mon_dat[k], exp3[k]);

    // Back-to-back blocks
    clear_mon();
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < LN; k++) blk[k*DW +: DW] = DW'(((b + 1) << 28) | k);
      if (b == 0) send_block(blk, 1'b0, acc);
      else if (b == 1) send_block(blk, 1'b0, acc_b);
      else send_block(blk, 1'b0, acc_c);
    end
    wait_cycles(30);
    check("b2b_acc_b", acc_b - acc, 1);
    check("b2b_acc_c", acc_c - acc, 9);
    check("b2b_count", mon_dat.size(), 24);
    for (int i = 0; i < 24 && i < mon_dat.size(); i++) begin
      check($sformatf("b2b_data%0d", i), mon_dat[i], DW'((((i / 8) + 1) << 28) | (i % 8)));
      check($sformatf("b2b_cyc%0d", i), mon_cyc[i], acc + i);
      check($sformatf("b2b_last%0d", i), mon_last[i], (i % 8 == 7) ? 1 : 0);
    end

    // Backpressure: alternate out_ready
    clear_mon();
    out_ready = 1'b0;
    for (int k = 0; k < LN; k++) blk[k*DW +: DW] = DW'(32'hC000_0000 + k * 32'h0011_0011);
    send_block(blk, 1'b0, acc);
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 2 == 0);
      @(negedge clk);
      if (!out_ready && out_valid) begin
        held   = out_data;
        held_l = out_last;
        @(posedge clk);
        #1;
        check($sformatf("hold_data%0d", i), out_data, held);
        check($sformatf("hold_last%0d", i), out_last, held_l);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("bp_count", mon_dat.size(), 8);
    for (int k = 0; k < LN && k < mon_dat.size(); k++)
      check($sformatf("bp_data%0d", k), mon_dat[k], DW'(32'hC000_0000 + k * 32'h0011_0011));
    check("bp_busy", busy, 0);

    // Mode toggles while blocks sit in shifter and buffer
    clear_mon();
    out_ready = 1'b0;
    send_block(blk2, 1'b0, acc);
    mode = 1'b1;
    send_block(blk3, 1'b1, acc_b);
    mode = 1'b0;
    wait_cycles(2);
    out_ready = 1'b1;
    wait_cycles(20);
    check("tog_count", mon_dat.size(), 16);
    for (int i = 0; i < 16 && i < mon_dat.size(); i++) begin
      e = (i < 8) ? DW'(32'h0001_0000 * (i + 1) + i) : exp3[i - 8];
      check($sformatf("tog_data%0d", i), mon_dat[i], e);
    end

    // Asynchronous reset in the middle of a block with the buffer full
    clear_mon();
    out_ready = 1'b0;
    send_block(blk2, 1'b0, acc);
    send_block(blk3, 1'b1, acc_b);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_pops", mon_dat.size(), 3);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    clear_mon();
    for (int k = 0; k < LN; k++) blk[k*DW +: DW] = DW'(32'h5000_0000 | k);
    send_block(blk, 1'b0, acc);
    wait_cycles(12);
    check("post_rst_count", mon_dat.size(), 8);
    for (int k = 0; k < LN && k < mon_dat.size(); k++)
      check($sformatf("post_rst_data%0d", k), mon_dat[k], DW'(32'h5000_0000 | k));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
